// File: rtl/dwc_pkg.sv
// Shared types and constants for the duplicate-with-compare producer path.
package dwc_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PARTIAL = 2'd1,
    PAIRED  = 2'd2,
    REPORT  = 2'd3
  } loader_state_t;

  localparam logic [1:0] DSET_NONE = 2'b00;
  localparam logic [1:0] DSET_A    = 2'b01;
  localparam logic [1:0] DSET_B    = 2'b10;
  localparam logic [1:0] DSET_PAIR = 2'b11;

  localparam int DWC_DATA_W = 32;

endpackage

// File: rtl/dwc_watchdog.sv
// Loadable up-counter with clear/enable; terminal is high while count sits at LIMIT-1.
module dwc_watchdog #(
  parameter int LIMIT = 1024,
  parameter int W     = $clog2(LIMIT)
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clear,
  input  logic         enable,
  input  logic         load,
  input  logic [W-1:0] load_value,
  output logic         terminal
);

  localparam logic [W-1:0] LAST = W'(LIMIT - 1);

  logic [W-1:0] count;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (load) begin
      count <= load_value;
    end else if (enable) begin
      count <= count + 1'b1;
    end
  end

  assign terminal = (count == LAST);

endmodule

// File: rtl/dwc_pair_loader.sv
// DWC pair loader: captures one result word per core, presents the pair to the comparator
// and reports the verdict by level interrupt. Define DWC_MISMATCH_CNT_EN for the mismatch counter.
module dwc_pair_loader
  import dwc_pkg::*;
#(
  parameter int DATA_W         = DWC_DATA_W,
  parameter int TIMEOUT_CYCLES = 1024,
  parameter int CNT_W          = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              wr_a,
  input  logic [DATA_W-1:0] wdata_a,
  output logic              ready_a,
  input  logic              wr_b,
  input  logic [DATA_W-1:0] wdata_b,
  output logic              ready_b,
  output logic [DATA_W-1:0] data_a,
  output logic [DATA_W-1:0] data_b,
  output logic [1:0]        data_set,
  input  logic              cmp_prompt,
  input  logic              cmp_match,
  output logic              irq,
  input  logic              irq_ack,
  output logic              res_match,
  output logic              res_timeout
`ifdef DWC_MISMATCH_CNT_EN
  ,
  output logic [CNT_W-1:0]  mismatch_cnt
`endif
);

  localparam int TIMER_W = $clog2(TIMEOUT_CYCLES);

  loader_state_t state, next_state;
  logic          wr_a_ok, wr_b_ok;
  logic          timer_done;
  logic          pair_done, timed_out;

  assign wr_a_ok   = wr_a & ready_a;
  assign wr_b_ok   = wr_b & ready_b;
  assign pair_done = (state == PAIRED) && cmp_prompt;
  assign timed_out = (state == PARTIAL) && (next_state == REPORT);

  // Timer runs only in PARTIAL and is held at zero everywhere else.
  dwc_watchdog #(
    .LIMIT (TIMEOUT_CYCLES),
    .W     (TIMER_W)
  ) u_watchdog (
    .clk        (clk),
    .reset      (reset),
    .clear      (state != PARTIAL),
    .enable     (state == PARTIAL),
    .load       (1'b0),
    .load_value ('0),
    .terminal   (timer_done)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // A completing write beats the watchdog on the terminal-count cycle.
  always_comb begin
    next_state = state;
    case (state)
      IDLE: begin
        if (wr_a_ok && wr_b_ok) begin
          next_state = PAIRED;
        end else if (wr_a_ok || wr_b_ok) begin
          next_state = PARTIAL;
        end
      end
      PARTIAL: begin
        if ((data_set[0] || wr_a_ok) && (data_set[1] || wr_b_ok)) begin
          next_state = PAIRED;
        end else if (timer_done) begin
          next_state = REPORT;
        end
      end
      PAIRED: begin
        if (cmp_prompt) begin
          next_state = REPORT;
        end
      end
      REPORT: begin
        if (irq_ack) begin
          next_state = IDLE;
        end
      end
      default: next_state = IDLE;
    endcase
  end

  always_comb begin
    ready_a = 1'b0;
    ready_b = 1'b0;
    if ((state == IDLE) || (state == PARTIAL)) begin
      ready_a = !data_set[0];
      ready_b = !data_set[1];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      data_a      <= '0;
      data_b      <= '0;
      data_set    <= DSET_NONE;
      irq         <= 1'b0;
      res_match   <= 1'b0;
      res_timeout <= 1'b0;
    end else begin
      if (wr_a_ok) begin
        data_a <= wdata_a;
      end
      if (wr_b_ok) begin
        data_b <= wdata_b;
      end
      // Clearing data_set on REPORT entry lets the comparator re-arm.
      if (next_state == REPORT) begin
        data_set <= DSET_NONE;
      end else begin
        data_set <= data_set | (wr_a_ok ? DSET_A : DSET_NONE) | (wr_b_ok ? DSET_B : DSET_NONE);
      end
      irq <= (next_state == REPORT);
      if (pair_done) begin
        res_match   <= cmp_match;
        res_timeout <= 1'b0;
      end else if (timed_out) begin
        res_match   <= 1'b0;
        res_timeout <= 1'b1;
      end
    end
  end

`ifdef DWC_MISMATCH_CNT_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mismatch_cnt <= '0;
    end else if (((pair_done && !cmp_match) || timed_out) && (mismatch_cnt != '1)) begin
      mismatch_cnt <= mismatch_cnt + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_dwc_pair_loader.sv
// Directed self-checking bench for dwc_pair_loader with an 8-cycle watchdog.
module tb_dwc_pair_loader;

  localparam int DW = 32;
  localparam int TO = 8;

  logic          clk;
  logic          reset;
  logic          wr_a, wr_b;
  logic [DW-1:0] wdata_a, wdata_b;
  logic          ready_a, ready_b;
  logic [DW-1:0] data_a, data_b;
  logic [1:0]    data_set;
  logic          cmp_prompt, cmp_match;
  logic          irq, irq_ack;
  logic          res_match, res_timeout;
`ifdef DWC_MISMATCH_CNT_EN
  logic [15:0]   mismatch_cnt;
`endif

  int tests = 0;
  int fails = 0;

  // {data_set, ready_a, ready_b, irq, res_match, res_timeout}
  logic [6:0] status;
  assign status = {data_set, ready_a, ready_b, irq, res_match, res_timeout};

  dwc_pair_loader #(
    .DATA_W         (DW),
    .TIMEOUT_CYCLES (TO),
    .CNT_W          (16)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .wr_a        (wr_a),
    .wdata_a     (wdata_a),
    .ready_a     (ready_a),
    .wr_b        (wr_b),
    .wdata_b     (wdata_b),
    .ready_b     (ready_b),
    .data_a      (data_a),
    .data_b      (data_b),
    .data_set    (data_set),
    .cmp_prompt  (cmp_prompt),
    .cmp_match   (cmp_match),
    .irq         (irq),
    .irq_ack     (irq_ack),
    .res_match   (res_match),
    .res_timeout (res_timeout)
`ifdef DWC_MISMATCH_CNT_EN
    ,
    .mismatch_cnt (mismatch_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    wr_a       = 1'b0;
    wr_b       = 1'b0;
    cmp_prompt = 1'b0;
    cmp_match  = 1'b0;
    irq_ack    = 1'b0;
  endtask

  task automatic ack_irq();
    irq_ack = 1'b1;
    tick();
    irq_ack = 1'b0;
  endtask

  task automatic test_reset();
    tests++;
    if (status !== 7'b00_11_000) begin
      fails++;
      $display("[TB] FAIL reset_status: got %b expected %b", status, 7'b00_11_000);
    end
    tests++;
    if ({data_a, data_b} !== 64'h0) begin
      fails++;
      $display("[TB] FAIL reset_data: got %h expected 0", {data_a, data_b});
    end
    reset = 1'b0;
    tick();
    tests++;
    if (status !== 7'b00_11_000) begin
      fails++;
      $display("[TB] FAIL reset_release: got %b expected %b", status, 7'b00_11_000);
    end
  endtask

  task automatic test_seq_match();
    wr_a = 1'b1; wdata_a = 32'hDEADBEEF;
    tick();
    wr_a = 1'b0;
    tests++;
    if (status !== 7'b01_01_000 || data_a !== 32'hDEADBEEF) begin
      fails++;
      $display("[TB] FAIL seq_first: got %b/%h expected %b/%h", status, data_a, 7'b01_01_000, 32'hDEADBEEF);
    end
    tick();
    tick();
    wr_b = 1'b1; wdata_b = 32'hDEADBEEF;
    tick();
    wr_b = 1'b0;
    tests++;
    if (status !== 7'b11_00_000 || data_b !== 32'hDEADBEEF) begin
      fails++;
      $display("[TB] FAIL seq_pair: got %b/%h expected %b/%h", status, data_b, 7'b11_00_000, 32'hDEADBEEF);
    end
    cmp_prompt = 1'b1; cmp_match = 1'b1;
    tick();
    cmp_prompt = 1'b0; cmp_match = 1'b0;
    tests++;
    if (status !== 7'b00_00_110) begin
      fails++;
      $display("[TB] FAIL seq_report: got %b expected %b", status, 7'b00_00_110);
    end
    tick();
    tests++;
    if (irq !== 1'b1) begin
      fails++;
      $display("[TB] FAIL seq_irq_hold: got %b expected 1", irq);
    end
    ack_irq();
    tests++;
    if (status !== 7'b00_11_010) begin
      fails++;
      $display("[TB] FAIL seq_ack: got %b expected %b", status, 7'b00_11_010);
    end
  endtask

  task automatic test_simul_mismatch();
    wr_a = 1'b1; wdata_a = 32'h1;
    wr_b = 1'b1; wdata_b = 32'h2;
    tick();
    wr_a = 1'b0; wr_b = 1'b0;
    tests++;
    if (status !== 7'b11_00_010 || data_a !== 32'h1 || data_b !== 32'h2) begin
      fails++;
      $display("[TB] FAIL simul_pair: got %b/%h/%h expected %b/1/2", status, data_a, data_b, 7'b11_00_010);
    end
    cmp_prompt = 1'b1; cmp_match = 1'b0;
    tick();
    cmp_prompt = 1'b0;
    tests++;
    if (status !== 7'b00_00_100) begin
      fails++;
      $display("[TB] FAIL simul_report: got %b expected %b", status, 7'b00_00_100);
    end
`ifdef DWC_MISMATCH_CNT_EN
    tests++;
    if (mismatch_cnt !== 16'd1) begin
      fails++;
      $display("[TB] FAIL simul_cnt: got %0d expected 1", mismatch_cnt);
    end
`endif
    ack_irq();
  endtask

  task automatic test_duplicate();
    wr_a = 1'b1; wdata_a = 32'h5;
    tick();
    wdata_a = 32'h6;
    tick();
    wr_a = 1'b0;
    tests++;
    if (data_a !== 32'h5 || data_set !== 2'b01) begin
      fails++;
      $display("[TB] FAIL dup_retain: got %h/%b expected 5/01", data_a, data_set);
    end
    wr_b = 1'b1; wdata_b = 32'h5;
    tick();
    wr_b = 1'b0;
    tests++;
    if (data_set !== 2'b11 || data_a !== 32'h5 || data_b !== 32'h5) begin
      fails++;
      $display("[TB] FAIL dup_pair: got %b/%h/%h expected 11/5/5", data_set, data_a, data_b);
    end
    cmp_prompt = 1'b1; cmp_match = 1'b1;
    tick();
    cmp_prompt = 1'b0; cmp_match = 1'b0;
    tests++;
    if (status !== 7'b00_00_110) begin
      fails++;
      $display("[TB] FAIL dup_report: got %b expected %b", status, 7'b00_00_110);
    end
    ack_irq();
  endtask

  task automatic test_timeout();
    wr_a = 1'b1; wdata_a = 32'hA;
    tick();
    wr_a = 1'b0;
    repeat (TO - 1) tick();
    tests++;
    if (status !== 7'b01_01_010) begin
      fails++;
      $display("[TB] FAIL timeout_early: got %b expected %b", status, 7'b01_01_010);
    end
    tick();
    tests++;
    if (status !== 7'b00_00_101) begin
      fails++;
      $display("[TB] FAIL timeout_report: got %b expected %b", status, 7'b00_00_101);
    end
`ifdef DWC_MISMATCH_CNT_EN
    tests++;
    if (mismatch_cnt !== 16'd2) begin
      fails++;
      $display("[TB] FAIL timeout_cnt: got %0d expected 2", mismatch_cnt);
    end
`endif
    wr_b = 1'b1; wdata_b = 32'h77;
    tick();
    wr_b = 1'b0;
    tests++;
    if (status !== 7'b00_00_101 || data_b !== 32'h5) begin
      fails++;
      $display("[TB] FAIL timeout_late_b: got %b/%h expected %b/5", status, data_b, 7'b00_00_101);
    end
    ack_irq();
    tests++;
    if (status !== 7'b00_11_001) begin
      fails++;
      $display("[TB] FAIL timeout_ack: got %b expected %b", status, 7'b00_11_001);
    end
  endtask

  task automatic test_timeout_boundary();
    wr_a = 1'b1; wdata_a = 32'hB0;
    tick();
    wr_a = 1'b0;
    repeat (TO - 1) tick();
    wr_b = 1'b1; wdata_b = 32'hB1;
    tick();
    wr_b = 1'b0;
    tests++;
    if (data_set !== 2'b11 || irq !== 1'b0 || data_b !== 32'hB1) begin
      fails++;
      $display("[TB] FAIL boundary_pair: got %b/%b/%h expected 11/0/b1", data_set, irq, data_b);
    end
    repeat (TO + 2) tick();
    tests++;
    if (data_set !== 2'b11 || irq !== 1'b0) begin
      fails++;
      $display("[TB] FAIL boundary_no_wd_paired: got %b/%b expected 11/0", data_set, irq);
    end
    cmp_prompt = 1'b1; cmp_match = 1'b1;
    tick();
    cmp_prompt = 1'b0; cmp_match = 1'b0;
    tests++;
    if (status !== 7'b00_00_110) begin
      fails++;
      $display("[TB] FAIL boundary_report: got %b expected %b", status, 7'b00_00_110);
    end
    ack_irq();
  endtask

  task automatic test_reset_mid_paired();
    wr_a = 1'b1; wdata_a = 32'h11;
    wr_b = 1'b1; wdata_b = 32'h22;
    tick();
    wr_a = 1'b0; wr_b = 1'b0;
    tests++;
    if (data_set !== 2'b11) begin
      fails++;
      $display("[TB] FAIL midrst_pair: got %b expected 11", data_set);
    end
    #2;
    reset = 1'b1;
    #1;
    tests++;
    if (status !== 7'b00_11_000 || {data_a, data_b} !== 64'h0) begin
      fails++;
      $display("[TB] FAIL midrst_async: got %b/%h expected %b/0", status, {data_a, data_b}, 7'b00_11_000);
    end
`ifdef DWC_MISMATCH_CNT_EN
    tests++;
    if (mismatch_cnt !== 16'd0) begin
      fails++;
      $display("[TB] FAIL midrst_cnt: got %0d expected 0", mismatch_cnt);
    end
`endif
    #2;
    reset = 1'b0;
    cmp_prompt = 1'b1; cmp_match = 1'b1;
    tick();
    cmp_prompt = 1'b0; cmp_match = 1'b0;
    tests++;
    if (status !== 7'b00_11_000) begin
      fails++;
      $display("[TB] FAIL midrst_prompt_ignored: got %b expected %b", status, 7'b00_11_000);
    end
  endtask

  initial begin
    reset   = 1'b1;
    wdata_a = '0;
    wdata_b = '0;
    idle_inputs();
    repeat (2) @(posedge clk);
    #1;
    test_reset();
    test_seq_match();
    test_simul_mismatch();
    test_duplicate();
    test_timeout();
    test_timeout_boundary();
    test_reset_mid_paired();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
